// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit destination field layout and node id widths.
package noc_pkg;

    localparam int unsigned FLIT_W_DEFAULT = 20;
    localparam int unsigned ID_W           = 2;
    localparam int unsigned DEST_W         = 2 * ID_W;
    localparam int unsigned DEST_MSB       = FLIT_W_DEFAULT - 1;
    localparam int unsigned DEST_LSB       = FLIT_W_DEFAULT - DEST_W;
    localparam int unsigned MAX_FLIT_W     = 64;

    // Destination {cluster, local} sits in the top DEST_W bits of a flit_w-wide flit.
    function automatic logic [DEST_W-1:0] flit_dest(input logic [MAX_FLIT_W-1:0] flit,
                                                   input int unsigned flit_w);
        logic [MAX_FLIT_W-1:0] sh;
        sh = flit >> (flit_w - DEST_W);
        return sh[DEST_W-1:0];
    endfunction

endpackage

// File: rtl/node_net_iface_if.sv
// PE-side ready/valid channels and router local-port channels of the node interface.
interface node_net_iface_if #(
    parameter int unsigned FLIT_W = 20
) ();

    logic [FLIT_W-1:0] pe_tx_data;
    logic              pe_tx_valid;
    logic              pe_tx_ready;
    logic [FLIT_W-1:0] pe_rx_data;
    logic              pe_rx_valid;
    logic              pe_rx_ready;
    logic [FLIT_W-1:0] rtr_inject;
    logic              rtr_inject_valid;
    logic              rtr_credit_in;
    logic [FLIT_W-1:0] rtr_eject;
    logic              rtr_eject_valid;
    logic              rtr_credit_out;

    modport slave (
        input  pe_tx_data, pe_tx_valid, pe_rx_ready,
        input  rtr_credit_in, rtr_eject, rtr_eject_valid,
        output pe_tx_ready, pe_rx_data, pe_rx_valid,
        output rtr_inject, rtr_inject_valid, rtr_credit_out
    );

    modport master (
        output pe_tx_data, pe_tx_valid, pe_rx_ready,
        output rtr_credit_in, rtr_eject, rtr_eject_valid,
        input  pe_tx_ready, pe_rx_data, pe_rx_valid,
        input  rtr_inject, rtr_inject_valid, rtr_credit_out
    );

endinterface

// File: rtl/net_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry a wrap bit to tell full from empty.
module net_sync_fifo #(
    parameter int unsigned W     = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/node_net_iface.sv
// Node network interface: buffered, credit-managed injection and ejection between a PE
// and the router local port, with destination checking, sticky error flags and counters.
module node_net_iface
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_W   = FLIT_W_DEFAULT,
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4,
    parameter int unsigned RTR_BUF  = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ID_W-1:0]  my_cluster,
    input  logic [ID_W-1:0]  my_local,
    node_net_iface_if.slave  bus,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] rx_count,
    output logic             err_misroute,
    output logic             err_overflow,
    output logic             err_credit
);

    localparam int unsigned      CRD_W   = $clog2(RTR_BUF + 1);
    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(RTR_BUF);

    logic              tx_full, tx_empty, tx_push, send;
    logic [FLIT_W-1:0] tx_head, rx_head;
    logic              rx_full, rx_empty, rx_pop, rx_accept, rx_overflow;
    logic [CRD_W-1:0]  credits;
    logic [FLIT_W-1:0] inject_q;
    logic              inject_valid_q, credit_out_q;
    logic              dest_ok;

    assign tx_push     = bus.pe_tx_valid && !tx_full;
    assign send        = !tx_empty && (credits != '0);
    assign rx_pop      = bus.pe_rx_ready && !rx_empty;
    assign rx_accept   = bus.rtr_eject_valid && (!rx_full || rx_pop);
    assign rx_overflow = bus.rtr_eject_valid && rx_full && !rx_pop;
    assign dest_ok     = flit_dest(MAX_FLIT_W'(bus.rtr_eject), FLIT_W) == {my_cluster, my_local};

    assign bus.pe_tx_ready      = !tx_full;
    assign bus.pe_rx_valid      = !rx_empty;
    assign bus.pe_rx_data       = rx_head;
    assign bus.rtr_inject       = inject_q;
    assign bus.rtr_inject_valid = inject_valid_q;
    assign bus.rtr_credit_out   = credit_out_q;

    net_sync_fifo #(.W(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (send),
        .din   (bus.pe_tx_data),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    net_sync_fifo #(.W(FLIT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.rtr_eject_valid),
        .pop   (rx_pop),
        .din   (bus.rtr_eject),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            inject_q       <= '0;
            inject_valid_q <= 1'b0;
            credit_out_q   <= 1'b0;
            credits        <= CRD_MAX;
            tx_count       <= '0;
            rx_count       <= '0;
            err_misroute   <= 1'b0;
            err_overflow   <= 1'b0;
            err_credit     <= 1'b0;
        end else begin
            inject_valid_q <= send;
            credit_out_q   <= rx_pop;
            if (send) begin
                inject_q <= tx_head;
                tx_count <= tx_count + CNT_W'(1);
            end
            if (rx_accept) rx_count <= rx_count + CNT_W'(1);
            // A send and a returned credit in the same cycle cancel out.
            case ({send, bus.rtr_credit_in})
                2'b10: credits <= credits - CRD_W'(1);
                2'b01: begin
                    if (credits == CRD_MAX) err_credit <= 1'b1;
                    else                    credits    <= credits + CRD_W'(1);
                end
                default: ;
            endcase
            if (bus.rtr_eject_valid && !dest_ok) err_misroute <= 1'b1;
            if (rx_overflow)                     err_overflow <= 1'b1;
        end
    end

endmodule

// File: doc/node_net_iface.md
Name: node_net_iface

Overview:
- Parametrised network interface between a node's processing element and the router's local (port 5) inject/eject channel.
- Replaces the direct PE-to-router wiring with buffered, credit-managed traffic.
- Decouples the PE with ready/valid handshakes on both directions.
- Adds destination checking, error flags and traffic counters.

Parameters:
FLIT_W, 20, flit width in bits; destination field is flit[FLIT_W-1 -: 4] = {cluster[1:0], local[1:0]}
TX_DEPTH, 4, injection FIFO depth (power of 2, >=2)
RX_DEPTH, 4, ejection FIFO depth (power of 2, >=2); the router starts with RX_DEPTH credits toward this block
RTR_BUF, 4, router local-input buffer depth; initial credit count
CNT_W, 16, traffic counter width

Ports:
clk  in  1  clock
rst  in  1  reset
my_cluster  in  2  node cluster id
my_local  in  2  node local id
pe_tx_data  in  FLIT_W  flit from PE
pe_tx_valid  in  1  PE flit valid
pe_tx_ready  out  1  injection FIFO not full
pe_rx_data  out  FLIT_W  head of ejection FIFO
pe_rx_valid  out  1  ejection FIFO not empty
pe_rx_ready  in  1  PE pops head
rtr_inject  out  FLIT_W  flit to router local input
rtr_inject_valid  out  1  one-cycle flit strobe
rtr_credit_in  in  1  router freed one local-input slot
rtr_eject  in  FLIT_W  flit from router local output
rtr_eject_valid  in  1  eject flit strobe
rtr_credit_out  out  1  one-cycle pulse per ejection slot freed
tx_count  out  CNT_W  flits injected (wraps)
rx_count  out  CNT_W  flits accepted from router (wraps)
err_misroute  out  1  sticky: ejected flit destination != {my_cluster,my_local}
err_overflow  out  1  sticky: eject strobe while RX FIFO full and not popping
err_credit  out  1  sticky: rtr_credit_in with credits == RTR_BUF

Behaviour:
- Reset is synchronous, active-high, on rising clk; one clock domain.
- On reset:
  - Both FIFOs empty.
  - credits = RTR_BUF.
  - All outputs 0 except pe_tx_ready = 1.
  - Counters and error flags cleared.
  - Reset mid-operation discards buffered flits without emitting credits.
- TX path:
  - PE write occurs when pe_tx_valid && pe_tx_ready.
  - pe_tx_ready = !tx_full, with no same-cycle bypass.
  - Send condition: tx FIFO non-empty and credits > 0. When met, pop the head into a registered rtr_inject, assert rtr_inject_valid for exactly one cycle, decrement credits and increment tx_count.
  - Minimum latency from PE write (cycle N) to rtr_inject_valid is cycle N+2. The FIFO write completes at N+1; the pop and register happen at N+1 and are visible at N+2.
  - Throughput is 1 flit/cycle while credits last.
  - rtr_inject holds its last value when not valid.
- Credits:
  - Counter width is clog2(RTR_BUF+1).
  - Send and rtr_credit_in in the same cycle: count unchanged.
  - Credit alone: +1. If credits == RTR_BUF, saturate and set err_credit.
  - credits == 0: sending stalls and flits stay buffered.
- RX path:
  - Every rtr_eject_valid is written to the RX FIFO; rx_count increments.
  - Destination field != {my_cluster,my_local}: flit is still stored and err_misroute is set.
  - Pop occurs when pe_rx_valid && pe_rx_ready.
  - pe_rx_data/pe_rx_valid are combinational from the FIFO head, so first-word fall-through is visible the cycle after the write.
  - Each pop produces rtr_credit_out = 1 in the next cycle; the output is registered, giving one pulse per pop.
  - Push and pop in the same cycle while full: push accepted, occupancy unchanged, no error.
  - Push while full without a pop: flit dropped, rx_count not incremented, err_overflow set.
- Error flags are sticky and cleared only by rst.

Decomposition:
- Shared package noc_pkg:
  - FLIT_W default
  - DEST_MSB/DEST_LSB field positions
  - cluster/local id widths (2)
  - function flit_dest(flit)
- Sub-module net_sync_fifo, instantiated twice.
  - Parameters: W, DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Pointers carry an extra wrap bit.
  - FWFT dout.
  - Simultaneous push+pop allowed when full or empty-with-push.

Test Plan:
- Reset then PE writes 3 flits 0xA1001/0xA1002/0xA1003 back-to-back -> rtr_inject_valid on cycles 2,3,4 after first write, in order; tx_count=3; credits=1.
- Write 6 flits with no rtr_credit_in -> exactly 4 injected, then stall; pe_tx_ready drops while 2 remain plus further writes; one credit pulse -> the 5th flit is sent next cycle.
- rtr_credit_in with credits=4 after reset -> err_credit=1, credits stay 4; send + credit in the same cycle with credits=2 -> credits stay 2.
- my_cluster=2, my_local=1: eject flit 0x9xxxx (dest 4'b1001) -> no error. Eject 0x3xxxx -> err_misroute=1; both flits are delivered to the PE.
- pe_rx_ready=0 with 4 ejects, then a 5th -> err_overflow=1, rx_count=4. Then pop while pushing -> accepted, and rtr_credit_out pulses one cycle after each pop.
- Assert rst with 2 flits in each FIFO -> next cycle pe_rx_valid=0, rtr_inject_valid=0, credits=4, counters=0, no rtr_credit_out pulses.
